// File: rtl/formula_task_scheduler.sv
// Purpose: in-order, round-robin dispatcher of (a,b,c) triples onto N_WORKERS external formula workers.
// Latency: triple accepted in cycle t -> w_arg_vld in t+1; result on res no earlier than t+2+L (L = worker latency).
// Backpressure: arg_rdy drops while the next ring slot is BUSY or holding an undelivered result; res/res_vld hold while res_rdy=0.
//
// Ports:
//   clk, rst            single clock, synchronous active-low reset
//   arg_vld/arg_rdy     upstream handshake for operands a, b, c
//   res_vld/res_rdy     downstream handshake for res (strict issue order)
//   w_arg_vld           one-cycle launch pulse per worker; w_a/w_b/w_c broadcast registered operands
//   w_res_vld, w_res    per-worker completion pulse and result (worker i at [i*W +: W])
//   in_flight           number of slots not IDLE (registered)
//   err                 sticky flag: a worker answered while its slot was not BUSY
module formula_task_scheduler #(
  parameter int N_WORKERS = 4,
  parameter int W         = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               arg_vld,
  output logic                               arg_rdy,
  input  logic [W-1:0]                       a,
  input  logic [W-1:0]                       b,
  input  logic [W-1:0]                       c,
  output logic                               res_vld,
  input  logic                               res_rdy,
  output logic [W-1:0]                       res,
  output logic [N_WORKERS-1:0]               w_arg_vld,
  output logic [W-1:0]                       w_a,
  output logic [W-1:0]                       w_b,
  output logic [W-1:0]                       w_c,
  input  logic [N_WORKERS-1:0]               w_res_vld,
  input  logic [N_WORKERS*W-1:0]             w_res,
  output logic [$clog2(N_WORKERS+1)-1:0]     in_flight,
  output logic                               err
);

  localparam int PW = $clog2(N_WORKERS);
  localparam int CW = $clog2(N_WORKERS + 1);
  localparam logic [PW-1:0] LAST = PW'(N_WORKERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_state_e;

  slot_state_e          state_q [N_WORKERS];
  slot_state_e          state_d [N_WORKERS];
  logic [W-1:0]         hold_q  [N_WORKERS];
  logic [W-1:0]         hold_d  [N_WORKERS];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [N_WORKERS-1:0] w_arg_vld_q, w_arg_vld_d;
  logic [W-1:0]         w_a_q, w_a_d;
  logic [W-1:0]         w_b_q, w_b_d;
  logic [W-1:0]         w_c_q, w_c_d;
  logic [CW-1:0]        in_flight_q, in_flight_d;
  logic                 err_q, err_d;
  logic                 issue;
  logic                 deliver;

  // Slots are used as a ring: the slot at wr_ptr is free only once the
  // result previously issued there has been delivered.
  assign arg_rdy = rst && (state_q[wr_ptr_q] == IDLE);
  assign res_vld = (state_q[rd_ptr_q] == DONE);
  assign res     = hold_q[rd_ptr_q];

  assign issue   = arg_vld && arg_rdy;
  assign deliver = res_vld && res_rdy;

  assign w_arg_vld = w_arg_vld_q;
  assign w_a       = w_a_q;
  assign w_b       = w_b_q;
  assign w_c       = w_c_q;
  assign in_flight = in_flight_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    w_arg_vld_d = '0;
    w_a_d       = w_a_q;
    w_b_d       = w_b_q;
    w_c_d       = w_c_q;
    err_d       = err_q;
    in_flight_d = '0;

    // Completions: any number of workers may answer in one cycle. A pulse
    // on a slot that is not waiting for a result is dropped and flagged.
    for (int i = 0; i < N_WORKERS; i++) begin
      if (w_res_vld[i]) begin
        if (state_q[i] == BUSY) begin
          state_d[i] = DONE;
          hold_d[i]  = w_res[i*W +: W];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Issue and delivery never target the same slot: wr_ptr points at an
    // IDLE slot, rd_ptr at a DONE one, and completion only touches BUSY.
    if (issue) begin
      state_d[wr_ptr_q]     = BUSY;
      w_arg_vld_d[wr_ptr_q] = 1'b1;
      w_a_d                 = a;
      w_b_d                 = b;
      w_c_d                 = c;
      wr_ptr_d              = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    end

    if (deliver) begin
      state_d[rd_ptr_q] = IDLE;
      rd_ptr_d          = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    // Occupancy is taken from the next state so the registered count
    // always matches the slot states of the same cycle.
    for (int i = 0; i < N_WORKERS; i++) begin
      if (state_d[i] != IDLE) begin
        in_flight_d = in_flight_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_WORKERS; i++) begin
        state_q[i] <= IDLE;
        hold_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      w_arg_vld_q <= '0;
      w_a_q       <= '0;
      w_b_q       <= '0;
      w_c_q       <= '0;
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      w_arg_vld_q <= w_arg_vld_d;
      w_a_q       <= w_a_d;
      w_b_q       <= w_b_d;
      w_c_q       <= w_c_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_formula_task_scheduler.sv
// Purpose: self-checking bench for formula_task_scheduler with a latency-programmable worker model.
// Latency: n/a (bench); each cycle is advanced by tick(), which also updates the reference model.
// Backpressure: bench drives arg_vld/res_rdy patterns, holding operands stable until accepted.
module tb_formula_task_scheduler;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic [W-1:0] sum;
    int           rdy;
  } task_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             arg_vld = 1'b0;
  logic             arg_rdy;
  logic [W-1:0]     a = '0, b = '0, c = '0;
  logic             res_vld;
  logic             res_rdy = 1'b0;
  logic [W-1:0]     res;
  logic [N-1:0]     w_arg_vld;
  logic [W-1:0]     w_a, w_b, w_c;
  logic [N-1:0]     mdl_vld = '0;
  logic [N-1:0]     inj_vld = '0;
  logic [N-1:0]     w_res_vld;
  logic [N*W-1:0]   w_res = '0;
  logic [CW-1:0]    in_flight;
  logic             err;

  assign w_res_vld = mdl_vld | inj_vld;

  formula_task_scheduler #(.N_WORKERS(N), .W(W)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .b(b), .c(c), .res_vld(res_vld), .res_rdy(res_rdy), .res(res),
    .w_arg_vld(w_arg_vld), .w_a(w_a), .w_b(w_b), .w_c(w_c),
    .w_res_vld(w_res_vld), .w_res(w_res), .in_flight(in_flight), .err(err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: outstanding tasks in issue order, each with the cycle
  // from which its result may be presented.
  task_t        exp_q[$];
  int           lat_q[$];
  int           launch_q[$];
  int           lat_lo = 3, lat_hi = 3;
  int           issued = 0;
  logic [N-1:0] exp_wvld = '0;
  int           n_tests = 0, n_fail = 0;

  task automatic tick();
    bit           acc, del, in_rst;
    int           lat, acc_cyc;
    logic [W-1:0] s;
    acc     = arg_vld && arg_rdy;
    del     = res_vld && res_rdy;
    in_rst  = !rst;
    acc_cyc = cyc;
    s       = a + b + c;
    @(posedge clk);
    #1;
    exp_wvld = '0;
    if (in_rst) begin
      exp_q.delete();
      launch_q.delete();
      issued = 0;
    end else begin
      if (del && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        if (lat_q.size() > 0) lat = lat_q.pop_front();
        else lat = int'($urandom_range(lat_hi, lat_lo));
        exp_q.push_back('{sum: s, rdy: acc_cyc + 2 + lat});
        launch_q.push_back(lat);
        exp_wvld[issued % N] = 1'b1;
        issued++;
      end
    end
  endtask

  // Worker model: answers a launch seen in cycle x with a+b+c in cycle x+L.
  initial begin : worker
    int           due [N];
    logic [W-1:0] val [N];
    bit           was_rst;
    for (int i = 0; i < N; i++) due[i] = -1;
    forever begin
      @(posedge clk);
      was_rst = !rst;
      #2;
      mdl_vld = '0;
      if (was_rst) begin
        for (int i = 0; i < N; i++) due[i] = -1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (due[i] == cyc) begin
            mdl_vld[i]       = 1'b1;
            w_res[i*W +: W]  = val[i];
            due[i]           = -1;
          end
          if (w_arg_vld[i]) begin
            if (launch_q.size() > 0) due[i] = cyc + launch_q.pop_front();
            else due[i] = cyc + 1;
            val[i] = w_a + w_b + w_c;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b0; arg_vld = 1'b0; res_rdy = 1'b0; inj_vld = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (arg_rdy !== 1'b0 || res_vld !== 1'b0 || err !== 1'b0 || in_flight !== '0 || w_arg_vld !== '0) begin
        n_fail++;
        $display("FAIL reset_state: arg_rdy=%b res_vld=%b err=%b in_flight=%0d w_arg_vld=%b, want all 0",
                 arg_rdy, res_vld, err, in_flight, w_arg_vld);
      end
    end
    n_tests++;
    if (w_a !== '0 || w_b !== '0 || w_c !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: w_a=%0h w_b=%0h w_c=%0h, want 0", w_a, w_b, w_c);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (arg_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: arg_rdy=%b, want 1", arg_rdy);
    end
  endtask

  task automatic test_single();
    lat_lo = 3; lat_hi = 3;
    res_rdy = 1'b1; a = 1; b = 2; c = 3; arg_vld = 1'b1;
    n_tests++;
    if (arg_rdy !== 1'b1) begin
      n_fail++; $display("FAIL single_rdy: arg_rdy=%b, want 1", arg_rdy);
    end
    tick();
    arg_vld = 1'b0;
    n_tests++;
    if (w_arg_vld !== 4'b0001) begin
      n_fail++; $display("FAIL single_launch: w_arg_vld=%b, want 0001", w_arg_vld);
    end
    n_tests++;
    if (in_flight !== CW'(1)) begin
      n_fail++; $display("FAIL single_in_flight: in_flight=%0d, want 1", in_flight);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      n_tests++;
      if (res_vld !== (k == 5)) begin
        n_fail++; $display("FAIL single_res_vld: t+%0d res_vld=%b, want %b", k, res_vld, (k == 5));
      end
    end
    n_tests++;
    if (res !== 32'd6) begin
      n_fail++; $display("FAIL single_res: res=%0d, want 6", res);
    end
    tick();
    n_tests++;
    if (in_flight !== '0 || res_vld !== 1'b0) begin
      n_fail++; $display("FAIL single_empty: in_flight=%0d res_vld=%b, want 0 0", in_flight, res_vld);
    end
  endtask

  task automatic test_full_stall();
    int n_acc;
    bit acc;
    n_acc = 0;
    lat_lo = 10; lat_hi = 10; res_rdy = 1'b1;
    a = $urandom; b = $urandom; c = $urandom;
    for (int k = 0; k < 14; k++) begin
      arg_vld = 1'b1;
      n_tests++;
      if (arg_rdy !== (k < 4 || k == 13)) begin
        n_fail++; $display("FAIL full_rdy: cycle %0d arg_rdy=%b, want %b", k, arg_rdy, (k < 4 || k == 13));
      end
      if (res_vld && res_rdy) begin
        n_tests++;
        if (exp_q.size() == 0 || res !== exp_q[0].sum) begin
          n_fail++; $display("FAIL full_res: cycle %0d res=%0h, unexpected", k, res);
        end
      end
      if (k == 8) begin
        n_tests++;
        if (n_acc != 4) begin
          n_fail++; $display("FAIL full_accepts: %0d accepted in 8 cycles, want 4", n_acc);
        end
      end
      acc = arg_rdy;
      if (acc) n_acc++;
      tick();
      if (acc) begin a = $urandom; b = $urandom; c = $urandom; end
    end
    arg_vld = 1'b0;
    n_tests++;
    if (w_arg_vld !== 4'b0001) begin
      n_fail++; $display("FAIL full_wrap: fifth launch w_arg_vld=%b, want 0001", w_arg_vld);
    end
    for (int g = 0; g < 100 && exp_q.size() > 0; g++) begin
      if (res_vld) begin
        n_tests++;
        if (res !== exp_q[0].sum) begin
          n_fail++; $display("FAIL full_drain_res: res=%0h, want %0h", res, exp_q[0].sum);
        end
      end
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL full_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_reorder();
    int ndel;
    ndel = 0;
    lat_q = '{9, 2, 2, 2};
    res_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      arg_vld = (k < 4);
      a = k; b = 10 * k; c = 100;
      if (res_vld) begin
        n_tests++;
        if (res !== W'(11 * ndel + 100) || k != 11 + ndel) begin
          n_fail++;
          $display("FAIL reorder: result %0d res=%0d at cycle %0d, want %0d at cycle %0d",
                   ndel, res, k, 11 * ndel + 100, 11 + ndel);
        end
        ndel++;
      end
      tick();
    end
    arg_vld = 1'b0;
    n_tests++;
    if (ndel != 4) begin
      n_fail++; $display("FAIL reorder_count: %0d results, want 4", ndel);
    end
  endtask

  task automatic test_backpressure();
    int           n_acc, ndel;
    bit           acc, have;
    logic [W-1:0] held;
    logic [W-1:0] sums [6];
    n_acc = 0; ndel = 0; have = 0; held = '0;
    lat_lo = 3; lat_hi = 3; res_rdy = 1'b0;
    a = $urandom; b = $urandom; c = $urandom;
    for (int k = 0; k < 20; k++) begin
      arg_vld = (n_acc < 6);
      if (res_vld) begin
        if (!have) begin
          held = res; have = 1;
        end else begin
          n_tests++;
          if (res !== held) begin
            n_fail++; $display("FAIL bp_stable: res=%0h, want held %0h", res, held);
          end
        end
      end
      acc = arg_vld && arg_rdy;
      if (acc) begin sums[n_acc] = a + b + c; n_acc++; end
      tick();
      if (acc) begin a = $urandom; b = $urandom; c = $urandom; end
    end
    n_tests++;
    if (n_acc != 4) begin
      n_fail++; $display("FAIL bp_accepts: %0d accepted, want 4", n_acc);
    end
    n_tests++;
    if (!have || held !== sums[0]) begin
      n_fail++; $display("FAIL bp_first: held=%0h valid=%b, want %0h", held, have, sums[0]);
    end
    res_rdy = 1'b1;
    for (int k = 0; k < 60 && ndel < 6; k++) begin
      arg_vld = (n_acc < 6);
      if (res_vld) begin
        n_tests++;
        if (res !== sums[ndel]) begin
          n_fail++; $display("FAIL bp_order: result %0d res=%0h, want %0h", ndel, res, sums[ndel]);
        end
        ndel++;
      end
      acc = arg_vld && arg_rdy;
      if (acc) begin sums[n_acc] = a + b + c; n_acc++; end
      tick();
      if (acc) begin a = $urandom; b = $urandom; c = $urandom; end
    end
    arg_vld = 1'b0;
    n_tests++;
    if (ndel != 6) begin
      n_fail++; $display("FAIL bp_count: %0d results, want 6", ndel);
    end
  endtask

  task automatic test_err();
    int  n_iss;
    bit  acc;
    n_iss = 0;
    inj_vld = 4'b0100;
    tick();
    inj_vld = '0;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_set: err=%b, want 1", err);
    end
    tick();
    tick();
    n_tests++;
    if (err !== 1'b1 || in_flight !== '0 || res_vld !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky: err=%b in_flight=%0d res_vld=%b, want 1 0 0", err, in_flight, res_vld);
    end
    lat_lo = 2; lat_hi = 2; res_rdy = 1'b1;
    a = $urandom; b = $urandom; c = $urandom;
    for (int k = 0; k < 40 && (n_iss < 4 || exp_q.size() > 0); k++) begin
      arg_vld = (n_iss < 4);
      if (res_vld) begin
        n_tests++;
        if (exp_q.size() == 0 || res !== exp_q[0].sum) begin
          n_fail++; $display("FAIL err_traffic: res=%0h, unexpected", res);
        end
      end
      acc = arg_vld && arg_rdy;
      if (acc) n_iss++;
      tick();
      if (acc) begin a = $urandom; b = $urandom; c = $urandom; end
    end
    arg_vld = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || n_iss != 4 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_recover: pending=%0d issued=%0d err=%b, want 0 4 1", exp_q.size(), n_iss, err);
    end
  endtask

  task automatic test_random();
    bit acc, exp_rv;
    lat_lo = 1; lat_hi = 6;
    arg_vld = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!arg_vld) begin
        arg_vld = ($urandom_range(9, 0) < 7);
        a = $urandom; b = $urandom; c = $urandom;
      end
      res_rdy = ($urandom_range(9, 0) < 6);
      exp_rv = 1'b0;
      if (exp_q.size() > 0) exp_rv = (exp_q[0].rdy <= cyc);
      n_tests++;
      if (arg_rdy !== (exp_q.size() < N)) begin
        n_fail++; $display("FAIL rnd_rdy: cycle %0d arg_rdy=%b, want %b", cyc, arg_rdy, (exp_q.size() < N));
      end
      n_tests++;
      if (res_vld !== exp_rv) begin
        n_fail++; $display("FAIL rnd_res_vld: cycle %0d res_vld=%b, want %b", cyc, res_vld, exp_rv);
      end
      if (res_vld && exp_rv) begin
        n_tests++;
        if (res !== exp_q[0].sum) begin
          n_fail++; $display("FAIL rnd_res: cycle %0d res=%0h, want %0h", cyc, res, exp_q[0].sum);
        end
      end
      n_tests++;
      if (in_flight !== CW'(exp_q.size())) begin
        n_fail++; $display("FAIL rnd_in_flight: cycle %0d in_flight=%0d, want %0d", cyc, in_flight, exp_q.size());
      end
      n_tests++;
      if (w_arg_vld !== exp_wvld) begin
        n_fail++; $display("FAIL rnd_launch: cycle %0d w_arg_vld=%b, want %b", cyc, w_arg_vld, exp_wvld);
      end
      acc = arg_vld && arg_rdy;
      tick();
      if (acc) arg_vld = 1'b0;
    end
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    for (int g = 0; g < 200 && exp_q.size() > 0; g++) begin
      if (res_vld) begin
        n_tests++;
        if (res !== exp_q[0].sum) begin
          n_fail++; $display("FAIL rnd_drain_res: res=%0h, want %0h", res, exp_q[0].sum);
        end
      end
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0 || err !== 1'b1) begin
      n_fail++; $display("FAIL rnd_drain: pending=%0d err=%b, want 0 1", exp_q.size(), err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_full_stall();
    test_reset();
    test_reorder();
    test_reset();
    test_backpressure();
    test_err();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
